// File: rtl/user_mem_loader.sv
// Host-side byte-stream loader for the 64 x 16 data memory.
// Parses {tag, base} / count / data-byte frames and freezes the core while writing.
module user_mem_loader #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned DATA_W  = 16,
   parameter logic [1:0]  HDR_TAG = 2'b10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [8:0]      MaxCount = 9'(1 << ADDR_W);
   localparam logic [ADDR_W:0] RemOne   = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {StIdle, StCount, StHi, StLo, StWrite, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [7:0]          hi_q, hi_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                err_q, err_d;
   logic                accept;
   logic                count_ok;

   assign accept   = in_valid & in_ready;
   assign count_ok = (in_data != 8'd0) && ({1'b0, in_data} <= MaxCount);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_data[7:6] == HDR_TAG) begin
                  addr_d  = in_data[ADDR_W-1:0];
                  hold_d  = 1'b1;
                  state_d = StCount;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StCount: begin
            if (accept) begin
               if (count_ok) begin
                  rem_d   = in_data[ADDR_W:0];
                  state_d = StHi;
               end else begin
                  err_d   = 1'b1;
                  hold_d  = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         StHi: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = StLo;
            end
         end
         StLo: begin
            if (accept) begin
               wdata_d = {hi_q, in_data};
               waddr_d = addr_q;
               state_d = StWrite;
            end
         end
         StWrite: begin
            // Address wraps naturally at the top of memory.
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == RemOne) ? StDone : StHi;
         end
         StDone: begin
            hold_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      mem_we    = 1'b0;
      load_done = 1'b0;
      busy      = (state_q != StIdle);
      unique case (state_q)
         StIdle, StCount, StHi, StLo: in_ready = ~rst;
         StWrite:                     mem_we    = 1'b1;
         StDone:                      load_done = 1'b1;
         default:                     in_ready  = 1'b0;
      endcase
   end

   assign mem_addr  = waddr_q;
   assign mem_wdata = wdata_q;
   assign cpu_hold  = hold_q;
   assign load_err  = err_q;

endmodule
